// File: rtl/gf256_pkg.sv
// gf256_pkg: GF(2^8) field constants, element/exponent types and antilog FSM states.
package gf256_pkg;
  localparam logic [8:0] PRIM_POLY = 9'h15F;
  typedef logic [7:0] gf_elem_t;
  typedef logic [7:0] gf_exp_t;
  // alpha^(2^i) for i = 0..7, entry i at slice [i]
  localparam logic [7:0][7:0] ALPHA_POW2 = {8'hC0, 8'h95, 8'h9A, 8'h86, 8'h5F, 8'h10, 8'h04, 8'h02};
  typedef enum logic [1:0] {IDLE, BUSY, DONE} state_t;
endpackage

// File: rtl/gf256_mul.sv
// gf256_mul: combinational GF(2^8) multiplier, Horner-style shift/reduce over b's bits.
module gf256_mul #(
  parameter logic [8:0] PRIM_POLY = 9'h15F
) (
  input  logic [7:0] a,
  input  logic [7:0] b,
  output logic [7:0] p
);
  always_comb begin
    p = 8'h00;
    for (int k = 7; k >= 0; k--)
      p = {p[6:0], 1'b0} ^ (p[7] ? PRIM_POLY[7:0] : 8'h00) ^ (b[k] ? a : 8'h00);
  end
endmodule

// File: rtl/gf_antilog_seq.sv
// gf_antilog_seq: sequential alpha^n via square-and-multiply over the 8 exponent bits.
module gf_antilog_seq
  import gf256_pkg::*;
#(
  parameter logic [8:0] PRIM_POLY = 9'h15F
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       in_valid,
  output logic       in_ready,
  input  logic [7:0] in_exp,
  input  logic       in_zero,
  output logic       out_valid,
  input  logic       out_ready,
  output logic [7:0] out_elem,
  output logic       busy
);
  state_t   state, state_d;
  gf_elem_t acc, prod;
  gf_exp_t  exp_q;
  logic     zero_q;
  logic [2:0] i;
  gf256_mul #(.PRIM_POLY(PRIM_POLY)) u_mul (.a(acc), .b(ALPHA_POW2[i]), .p(prod));
  always_comb begin
    state_d = state;
    state_d = (state == IDLE && in_valid)  ? BUSY :
              (state == BUSY && i == 3'd7) ? DONE :
              (state == DONE && out_ready) ? IDLE : state;
  end
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state  <= IDLE;
      acc    <= 8'h01;
      i      <= 3'd0;
      exp_q  <= 8'h00;
      zero_q <= 1'b0;
    end else begin
      state <= state_d;
      if (state == IDLE && in_valid) begin
        exp_q  <= in_exp;
        zero_q <= in_zero;
        acc    <= 8'h01;
        i      <= 3'd0;
      end else if (state == BUSY) begin
        if (exp_q[i]) acc <= prod;
        i <= i + 3'd1;
      end
    end
  end
  assign in_ready  = state == IDLE;
  assign out_valid = state == DONE;
  assign busy      = state != IDLE;
  // exponent 255 needs no special case: alpha^255 = 1 falls out of the product
  assign out_elem  = (out_valid && !zero_q) ? acc : 8'h00;
endmodule

// File: doc/gf_antilog_seq.md
# gf_antilog_seq

Sequential GF(2^8) antilog unit: accepts an exponent n and returns the field element alpha^n. It is the inverse direction of the decoder's log (element-to-exponent) lookup. It uses square-and-multiply over the eight exponent bits with one shared GF multiplier, not a 255-entry table. It sits in the Unity ECC decoder datapath after exponent arithmetic (error-location/value computation), converting exponent sums back to symbols.

## Interface
Parameters:
- PRIM_POLY, 9'h15F, primitive polynomial x^8+x^6+x^4+x^3+x^2+x+1, the same field as the decoder log lookup.

Ports:
- clk  in  1  clock
- rst  in  1  reset, asynchronous, active-high
- in_valid  in  1  request valid
- in_ready  out  1  block can accept a request; high only in IDLE
- in_exp  in  8  exponent n, 0..255; 255 is treated as alpha^255 = 1
- in_zero  in  1  operand is the zero element; result forced to 8'h00
- out_valid  out  1  result valid; held until consumed
- out_ready  in  1  consumer accepts the result
- out_elem  out  8  alpha^n, or 8'h00 if the captured zero flag is set
- busy  out  1  high in BUSY or DONE

## Operation
- FSM states: IDLE, BUSY, DONE.
- IDLE:
  - in_ready = 1.
  - On in_valid && in_ready: capture in_exp into exp_q and in_zero into zero_q; set acc = 8'h01 and bit index i = 0; go to BUSY.
- BUSY, one iteration per cycle:
  - If exp_q[i], then acc <= gf_mul(acc, ALPHA_POW2[i]); otherwise acc holds.
  - i increments. After the iteration with i = 7, go to DONE.
  - There is no early exit; latency is fixed.
- ALPHA_POW2[0..7] = 02, 04, 10, 5F, 86, 9A, 95, C0 (hex), i.e. alpha^(2^i) reduced by PRIM_POLY.
- DONE:
  - out_valid = 1; out_elem = zero_q ? 8'h00 : acc.
  - On out_ready, go to IDLE.
  - out_elem stays stable while out_valid && !out_ready.
- All arithmetic is in GF(2^8): XOR addition, polynomial multiply reduced mod PRIM_POLY. No integer carries.
- Exponent 0 and exponent 255 both yield 8'h01.
- in_zero does not shorten latency; the element is still computed and then masked.

## Timing
- Reset values: state = IDLE, in_ready = 1, out_valid = 0, out_elem = 8'h00, busy = 0, acc = 8'h01, i = 0, exp_q = 0, zero_q = 0.
- Latency:
  - Accept at edge E0.
  - Iterations occur at edges E1..E8.
  - out_valid is high in the cycle following E8, i.e. visible 8 cycles after acceptance.
- Throughput: at least 10 cycles per request (accept, 8 busy cycles, 1 DONE cycle with out_ready already high).
- out_valid is registered. in_ready is a decode of the state register and has no combinational path from out_ready.
- in_valid while not in IDLE is ignored; the request stays pending on the producer side.
- out_ready while not in DONE has no effect.
- Reset asserted mid-operation (BUSY or DONE): immediate return to reset values; the pending result is discarded and no out_valid pulse occurs.
- The gf_mul path is purely combinational, single cycle: 8x8 AND array plus reduction XOR tree.

## Structure
- Package gf256_pkg holds:
  - PRIM_POLY.
  - typedef gf_elem_t = logic [7:0].
  - typedef gf_exp_t = logic [7:0].
  - ALPHA_POW2 constant array.
  - The FSM state enum (IDLE, BUSY, DONE).
- gf256_pkg is shared with the decoder's log lookup and syndrome logic.
- One sub-module, gf256_mul: combinational multiplier, inputs a and b, output p, reduction by PRIM_POLY. It is reused elsewhere in the decoder.
- The top level holds the FSM, the 3-bit bit counter, and the exp_q/zero_q/acc registers.

## Test plan
- Reset, then in_exp = 8 with in_zero = 0, out_ready = 1 → out_elem = 8'h5F, out_valid exactly 8 cycles after acceptance, in_ready low throughout.
- in_exp = 10 → 8'h23; in_exp = 89 → 8'hFF; in_exp = 200 → 8'h79; in_exp = 254 → 8'hAF.
- Boundaries:
  - in_exp = 0 → 8'h01.
  - in_exp = 255 → 8'h01.
  - in_exp = 77 with in_zero = 1 → 8'h00, same 8-cycle latency.
- Backpressure: out_ready held low for 5 cycles after out_valid → out_elem stays stable, in_valid is ignored meanwhile, and the block returns to IDLE on the first out_ready cycle.
- Reset pulse on the 4th BUSY cycle of in_exp = 8 → all outputs return to reset values immediately, no out_valid afterwards, and the next request in_exp = 1 → 8'h02.
- Exhaustive sweep n = 0..254 through the handshake → every result matches iterated multiply-by-alpha from 8'h01, and all 255 values are distinct.
